// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cmp_state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   localparam cmp_res_t RES_NONE = '0;

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit greater/equal cascade cell, walked MSB first.
// Latency: combinational.
// Backpressure: none; evaluated whenever the sequencer presents a bit.
// Ports: a/b operand bits, e_in/g_in running state in, e_out/g_out running state out.
module cmp_bit_cell (
   input  logic a,
   input  logic b,
   input  logic e_in,
   input  logic g_in,
   output logic e_out,
   output logic g_out
);

   // Only a bit seen while all higher bits were equal can decide "greater".
   assign g_out = g_in | (e_in & a & ~b);
   assign e_out = e_in & ~(a ^ b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks a/b MSB->LSB through one cascade cell.
// Latency: WIDTH clocks from accept to out_valid (k+1 on a difference at MSB index k when EARLY_EXIT).
// Backpressure: result held in DONE until out_ready; in_ready is low while RUN or stalled in DONE.
// Ports: clk/rst (async, active high); in_valid/in_ready/a/b operand handshake; abort cancels RUN;
//        out_valid/out_ready/gt/eq/lt result handshake; busy high in RUN; bits_used bits processed.
module serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int EARLY_EXIT = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       abort,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       gt,
   output logic                       eq,
   output logic                       lt,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bits_used
);

   localparam int IW = $clog2(WIDTH);
   localparam int BW = $clog2(WIDTH+1);

   cmp_state_t       state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic             e_q, g_q;
   logic             e_nxt, g_nxt;
   logic             accept;
   logic             last_bit;
   cmp_res_t         res;

   cmp_bit_cell u_cell (
      .a     (a_q[idx]),
      .b     (b_q[idx]),
      .e_in  (e_q),
      .g_in  (g_q),
      .e_out (e_nxt),
      .g_out (g_nxt)
   );

   assign accept   = in_valid & in_ready;
   assign last_bit = (idx == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; abort wins over completion in RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = ST_RUN;
         ST_RUN: begin
            if (abort)
               state_nxt = ST_IDLE;
            else if (last_bit || ((EARLY_EXIT != 0) && !e_nxt))
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            // Consuming the result and accepting new operands can share one edge.
            if (out_ready) state_nxt = in_valid ? ST_RUN : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode from registered state only, so they stay glitch-free while held.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      res       = RES_NONE;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_RUN:  busy     = 1'b1;
         ST_DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            res.gt    = g_q;
            res.eq    = e_q;
            res.lt    = ~g_q & ~e_q;
         end
         default: ;
      endcase
   end

   assign gt = res.gt;
   assign eq = res.eq;
   assign lt = res.lt;

   // Datapath: operand capture, cascade state, bit index and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         e_q       <= 1'b1;
         g_q       <= 1'b0;
         idx       <= '0;
         bits_used <= '0;
      end else if (accept) begin
         a_q       <= a;
         b_q       <= b;
         e_q       <= 1'b1;
         g_q       <= 1'b0;
         idx       <= IW'(WIDTH-1);
         bits_used <= '0;
      end else if (state == ST_RUN) begin
         if (abort) begin
            bits_used <= '0;
         end else begin
            e_q       <= e_nxt;
            g_q       <= g_nxt;
            // Wraps after the LSB; harmless because RUN is left on that edge.
            idx       <= idx - IW'(1);
            bits_used <= bits_used + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
module tb_serial_cmp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid  [2];
   logic       abort_s   [2];
   logic       out_ready [2];
   logic [3:0] a_s       [2];
   logic [3:0] b_s       [2];
   logic       in_ready  [2];
   logic       out_valid [2];
   logic       gt        [2];
   logic       eq        [2];
   logic       lt        [2];
   logic       busy      [2];
   logic [2:0] bits_used [2];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Instance 0: full-width walk; instance 1: early exit.
   serial_cmp_ctrl #(.WIDTH(4), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s[0]), .b(b_s[0]), .abort(abort_s[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]),
      .busy(busy[0]), .bits_used(bits_used[0])
   );

   serial_cmp_ctrl #(.WIDTH(4), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s[1]), .b(b_s[1]), .abort(abort_s[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]),
      .busy(busy[1]), .bits_used(bits_used[1])
   );

   // Reference model: relation from plain arithmetic, {gt,eq,lt}.
   function automatic logic [2:0] ref_rel(input logic [3:0] x, input logic [3:0] y);
      if (x > y)  return 3'b100;
      if (x == y) return 3'b010;
      return 3'b001;
   endfunction

   // Bits consumed (equal to latency): all 4, or up to the first differing bit from the MSB.
   function automatic int ref_bits(input int m, input logic [3:0] x, input logic [3:0] y);
      if (m == 0 || x == y) return 4;
      for (int i = 3; i >= 0; i--)
         if (x[i] != y[i]) return 4 - i;
      return 4;
   endfunction

   // Call at a negedge; returns at the negedge after the accepting posedge.
   task automatic do_accept(input int m, input logic [3:0] av, input logic [3:0] bv);
      int n = 0;
      in_valid[m] = 1'b1; a_s[m] = av; b_s[m] = bv;
      while (!in_ready[m] && n < 50) begin @(negedge clk); n++; end
      vectors++;
      if (in_ready[m] !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_timeout m=%0d in_ready=%b required 1", m, in_ready[m]);
      end
      @(posedge clk); @(negedge clk);
      in_valid[m] = 1'b0;
      // Scramble the source to show the operands were latched.
      a_s[m] = ~av; b_s[m] = ~bv;
   endtask

   task automatic wait_result(input int m, output int lat);
      lat = 0;
      while (!out_valid[m] && lat < 50) begin @(negedge clk); lat++; end
   endtask

   task automatic consume(input int m);
      out_ready[m] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready[m] = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         in_valid[m] = 0; abort_s[m] = 0; out_ready[m] = 0; a_s[m] = 0; b_s[m] = 0;
      end
      #3;
      for (int m = 0; m < 2; m++) begin
         vectors++;
         if ({in_ready[m], out_valid[m], gt[m], eq[m], lt[m], busy[m], bits_used[m]} !== 9'b1_0000_0000) begin
            miscompares++;
            $display("FAIL reset_state m=%0d got rdy=%b vld=%b gel=%b%b%b busy=%b bits=%0d required rdy=1 rest 0",
                     m, in_ready[m], out_valid[m], gt[m], eq[m], lt[m], busy[m], bits_used[m]);
         end
      end
      @(negedge clk); rst = 1'b0; @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         vectors++;
         if (in_ready[m] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready m=%0d got %b required 1", m, in_ready[m]);
         end
      end
   endtask

   // Directed op with full result check; leaves the result held (not consumed).
   task automatic run_directed(input string name, input int m, input logic [3:0] x, input logic [3:0] y);
      int lat;
      do_accept(m, x, y);
      wait_result(m, lat);
      vectors++;
      if (lat != ref_bits(m, x, y)) begin
         miscompares++;
         $display("FAIL %s_latency got %0d required %0d", name, lat, ref_bits(m, x, y));
      end
      vectors++;
      if ({gt[m], eq[m], lt[m]} !== ref_rel(x, y)) begin
         miscompares++;
         $display("FAIL %s_result got %b required %b", name, {gt[m], eq[m], lt[m]}, ref_rel(x, y));
      end
      vectors++;
      if (bits_used[m] !== 3'(ref_bits(m, x, y))) begin
         miscompares++;
         $display("FAIL %s_bits got %0d required %0d", name, bits_used[m], ref_bits(m, x, y));
      end
   endtask

   task automatic test_full_width;
      run_directed("fw_A_9", 0, 4'hA, 4'h9);
      consume(0);
      vectors++;
      if ({out_valid[0], gt[0], in_ready[0]} !== 3'b001) begin
         miscompares++;
         $display("FAIL fw_release got vld=%b gt=%b rdy=%b required 0 0 1", out_valid[0], gt[0], in_ready[0]);
      end
   endtask

   task automatic test_early_exit;
      run_directed("ee_8_7", 1, 4'b1000, 4'b0111); consume(1);
      run_directed("ee_3_C", 1, 4'h3, 4'hC);       consume(1);
      run_directed("ee_5_4", 1, 4'h5, 4'h4);       consume(1);
   endtask

   task automatic test_equal;
      run_directed("eq_m0", 0, 4'h5, 4'h5); consume(0);
      run_directed("eq_m1", 1, 4'h5, 4'h5); consume(1);
   endtask

   task automatic test_back_to_back;
      run_directed("bp_first", 0, 4'hC, 4'h4);
      repeat (10) begin
         @(negedge clk);
         vectors++;
         if ({out_valid[0], gt[0], eq[0], lt[0], in_ready[0]} !== 5'b11000) begin
            miscompares++;
            $display("FAIL bp_hold got vld=%b gel=%b%b%b rdy=%b required 1 100 0",
                     out_valid[0], gt[0], eq[0], lt[0], in_ready[0]);
         end
      end
      out_ready[0] = 1'b1; in_valid[0] = 1'b1; a_s[0] = 4'h1; b_s[0] = 4'h2;
      #1;
      vectors++;
      if (in_ready[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready got %b required 1", in_ready[0]);
      end
      @(posedge clk); @(negedge clk);
      out_ready[0] = 1'b0; in_valid[0] = 1'b0; a_s[0] = 4'hF; b_s[0] = 4'h0;
      vectors++;
      if ({busy[0], out_valid[0]} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_no_bubble got busy=%b vld=%b required 1 0", busy[0], out_valid[0]);
      end
      begin
         int lat;
         wait_result(0, lat);
         vectors++;
         if (lat != 4 || {gt[0], eq[0], lt[0]} !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_result got lat=%0d gel=%b required 4 001", lat, {gt[0], eq[0], lt[0]});
         end
      end
      consume(0);
   endtask

   task automatic test_abort;
      do_accept(0, 4'h3, 4'h3);
      @(negedge clk);
      abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
      vectors++;
      if ({busy[0], in_ready[0], out_valid[0], bits_used[0]} !== 6'b010_000) begin
         miscompares++;
         $display("FAIL abort_run got busy=%b rdy=%b vld=%b bits=%0d required 0 1 0 0",
                  busy[0], in_ready[0], out_valid[0], bits_used[0]);
      end
      repeat (6) begin
         @(negedge clk);
         vectors++;
         if (out_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_valid got %b required 0", out_valid[0]);
         end
      end
      // Abort while holding a result must not discard it.
      run_directed("abort_done", 0, 4'h9, 4'h3);
      abort_s[0] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({out_valid[0], gt[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_done_hold got vld=%b gt=%b required 1 1", out_valid[0], gt[0]);
         end
      end
      abort_s[0] = 1'b0;
      consume(0);
   endtask

   task automatic test_reset_mid;
      do_accept(1, 4'h7, 4'h7);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy[1], out_valid[1]} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_mid_run got busy=%b vld=%b required 0 0", busy[1], out_valid[1]);
      end
      @(negedge clk); rst = 1'b0;
      run_directed("pre_rst_done", 0, 4'h2, 4'hE);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid[0], lt[0]} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_mid_done got vld=%b lt=%b required 0 0", out_valid[0], lt[0]);
      end
      @(negedge clk); rst = 1'b0; @(negedge clk);
   endtask

   task automatic test_random(input int m, input int nops);
      logic [3:0] x, y;
      logic [2:0] held;
      bit pending = 0;
      int lat, stall;
      for (int i = 0; i < nops; i++) begin
         if (!pending) begin
            x = 4'($urandom);
            y = ($urandom_range(0, 3) == 0) ? x : 4'($urandom);
            do_accept(m, x, y);
         end
         wait_result(m, lat);
         vectors++;
         if (lat != ref_bits(m, x, y) || {gt[m], eq[m], lt[m]} !== ref_rel(x, y) ||
             bits_used[m] !== 3'(ref_bits(m, x, y))) begin
            miscompares++;
            $display("FAIL rand_m%0d a=%h b=%h got lat=%0d gel=%b bits=%0d required %0d %b %0d",
                     m, x, y, lat, {gt[m], eq[m], lt[m]}, bits_used[m],
                     ref_bits(m, x, y), ref_rel(x, y), ref_bits(m, x, y));
         end
         vectors++;
         if ($countones({gt[m], eq[m], lt[m]}) != 1) begin
            miscompares++;
            $display("FAIL rand_onehot m=%0d got %b required one bit set", m, {gt[m], eq[m], lt[m]});
         end
         held  = ref_rel(x, y);
         stall = $urandom_range(0, 3);
         repeat (stall) begin
            @(negedge clk);
            vectors++;
            if (out_valid[m] !== 1'b1 || {gt[m], eq[m], lt[m]} !== held) begin
               miscompares++;
               $display("FAIL rand_stall m=%0d got vld=%b gel=%b required 1 %b",
                        m, out_valid[m], {gt[m], eq[m], lt[m]}, held);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            x = 4'($urandom);
            y = ($urandom_range(0, 3) == 0) ? x : 4'($urandom);
            in_valid[m] = 1'b1; a_s[m] = x; b_s[m] = y; out_ready[m] = 1'b1;
            @(posedge clk); @(negedge clk);
            in_valid[m] = 1'b0; out_ready[m] = 1'b0; a_s[m] = ~x; b_s[m] = ~y;
            pending = 1;
         end else begin
            consume(m);
            pending = 0;
         end
      end
      if (pending) begin
         wait_result(m, lat);
         consume(m);
      end
   endtask

   initial begin
      test_reset();
      test_full_width();
      test_early_exit();
      test_equal();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random(0, 500);
      test_random(1, 500);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
